// File: rtl/spectrum_pkg.sv
// Shared definitions for the spectrum-display sample path.
//   state_e     : streamer state machine encoding
//   FFT_*       : default frame geometry (1024 bins, 10-bit bin address, 32-bit parts)
//   pair_count  : number of even/odd bin pairs in a frame of n_points bins
package spectrum_pkg;

  localparam int FFT_N      = 1024;
  localparam int FFT_ADDR_W = 10;
  localparam int FFT_DATA_W = 32;
  localparam int FFT_PAIRS  = FFT_N / 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DISP,
    ST_READ,
    ST_DRAIN,
    ST_START
  } state_e;

  function automatic int pair_count(input int n_points);
    return n_points / 2;
  endfunction

endpackage

// File: rtl/fft_result_streamer_if.sv
// Bus bundle between the FFT result RAM / FFT core / display path and the streamer.
//   FFT core side   : fft_complete_i
//   display side    : vga_busy_i, samples, write addresses, fft_done_o, vga_start_o
//   result RAM side : fft_rd_en_o, two read addresses, two complex read data ports
//   status          : busy_o, overrun_o
// modport master is the streamer itself; modport slave is its environment.
interface fft_result_streamer_if
  import spectrum_pkg::*;
#(
  parameter int ADDR_W = FFT_ADDR_W,
  parameter int DATA_W = FFT_DATA_W
);

  logic              fft_complete_i;
  logic              vga_busy_i;
  logic              fft_rd_en_o;
  logic [ADDR_W-1:0] fft_rd_addr_a_o;
  logic [ADDR_W-1:0] fft_rd_addr_b_o;
  logic [DATA_W-1:0] fft_rdata_a_real_i;
  logic [DATA_W-1:0] fft_rdata_a_img_i;
  logic [DATA_W-1:0] fft_rdata_b_real_i;
  logic [DATA_W-1:0] fft_rdata_b_img_i;
  logic [DATA_W-1:0] fft_sample1_real_o;
  logic [DATA_W-1:0] fft_sample1_img_o;
  logic [DATA_W-1:0] fft_sample2_real_o;
  logic [DATA_W-1:0] fft_sample2_img_o;
  logic [ADDR_W-1:0] write_vga_buffer_address1_o;
  logic [ADDR_W-1:0] write_vga_buffer_address2_o;
  logic              fft_done_o;
  logic              vga_start_o;
  logic              busy_o;
  logic              overrun_o;

  modport master (
    input  fft_complete_i, vga_busy_i,
    input  fft_rdata_a_real_i, fft_rdata_a_img_i, fft_rdata_b_real_i, fft_rdata_b_img_i,
    output fft_rd_en_o, fft_rd_addr_a_o, fft_rd_addr_b_o,
    output fft_sample1_real_o, fft_sample1_img_o, fft_sample2_real_o, fft_sample2_img_o,
    output write_vga_buffer_address1_o, write_vga_buffer_address2_o,
    output fft_done_o, vga_start_o, busy_o, overrun_o
  );

  modport slave (
    output fft_complete_i, vga_busy_i,
    output fft_rdata_a_real_i, fft_rdata_a_img_i, fft_rdata_b_real_i, fft_rdata_b_img_i,
    input  fft_rd_en_o, fft_rd_addr_a_o, fft_rd_addr_b_o,
    input  fft_sample1_real_o, fft_sample1_img_o, fft_sample2_real_o, fft_sample2_img_o,
    input  write_vga_buffer_address1_o, write_vga_buffer_address2_o,
    input  fft_done_o, vga_start_o, busy_o, overrun_o
  );

endinterface

// File: rtl/rd_valid_pipe.sv
// RD_LAT-deep register chain carrying {valid, even bin address} alongside the
// result RAM read, so the address arrives together with the read data.
//   clk, rst_n : clock, synchronous active-low reset (clears every stage)
//   vld_i      : read issued this cycle
//   addr_i     : even bin address of the issued read
//   vld_o      : delayed valid, aligned with RAM read data
//   addr_o     : delayed even bin address
//   any_vld_o  : some read is still in flight
module rd_valid_pipe #(
  parameter int RD_LAT = 2,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              vld_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              any_vld_o
);

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [ADDR_W-1:0] addr_q [RD_LAT];
  logic [ADDR_W-1:0] addr_d [RD_LAT];

  always_comb begin
    vld_d = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      addr_d[i] = '0;
    end
    vld_d[0]  = vld_i;
    addr_d[0] = addr_i;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      addr_d[i] = addr_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < RD_LAT; i++) begin
        addr_q[i] <= addr_d[i];
      end
    end
  end

  assign vld_o     = vld_q[RD_LAT-1];
  assign addr_o    = addr_q[RD_LAT-1];
  assign any_vld_o = |vld_q;

endmodule

// File: rtl/fft_result_streamer.sv
// Streams a finished FFT frame, two bins per cycle, from the FFT result RAM into
// the display magnitude buffer, then pulses vga_start_o to launch the display.
//   clk, rst_n : single clock, synchronous active-low reset
//   bus        : fft_result_streamer_if.master
//                in : fft_complete_i, vga_busy_i, RAM read data (ports A/B)
//                out: RAM read enable/addresses, samples, buffer write addresses,
//                     fft_done_o strobe, vga_start_o, busy_o, overrun_o
// One extra frame may be queued while busy; a further one is dropped with overrun_o.
module fft_result_streamer
  import spectrum_pkg::*;
#(
  parameter int N_POINTS = FFT_N,
  parameter int ADDR_W   = FFT_ADDR_W,
  parameter int DATA_W   = FFT_DATA_W,
  parameter int RD_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fft_result_streamer_if.master bus
);

  localparam int              PAIRS  = pair_count(N_POINTS);
  localparam int              K_W    = ADDR_W - 1;
  localparam logic [K_W-1:0]  K_LAST = K_W'(PAIRS - 1);

  state_e            state_q, state_d;
  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic [K_W-1:0]    k_q, k_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [ADDR_W-1:0] rd_addr_b_q, rd_addr_b_d;

  logic              done_q, done_d;
  logic [ADDR_W-1:0] wa1_q, wa1_d, wa2_q, wa2_d;
  logic [DATA_W-1:0] s1r_q, s1r_d, s1i_q, s1i_d, s2r_q, s2r_d, s2i_q, s2i_d;

  logic              pipe_vld;
  logic [ADDR_W-1:0] pipe_addr;
  logic              pipe_any;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    overrun_d   = 1'b0;
    k_d         = k_q;
    rd_en_d     = 1'b0;
    rd_addr_a_d = rd_addr_a_q;
    rd_addr_b_d = rd_addr_b_q;

    case (state_q)
      ST_IDLE: begin
        if (pending_q || bus.fft_complete_i) begin
          state_d   = bus.vga_busy_i ? ST_WAIT_DISP : ST_READ;
          k_d       = '0;
          // A queued frame is consumed here; a fresh pulse in the same cycle becomes the next queued one.
          pending_d = pending_q && bus.fft_complete_i;
        end
      end
      ST_WAIT_DISP: begin
        if (!bus.vga_busy_i) state_d = ST_READ;
      end
      ST_READ: begin
        rd_en_d     = 1'b1;
        rd_addr_a_d = {k_q, 1'b0};
        rd_addr_b_d = {k_q, 1'b1};
        k_d         = k_q + 1'b1;
        if (k_q == K_LAST) begin
          state_d = ST_DRAIN;
          k_d     = '0;
        end
      end
      ST_DRAIN: begin
        // The last read is out of the delay line once neither the issue register nor any stage holds it.
        if (!rd_en_q && !pipe_any) state_d = ST_START;
      end
      ST_START: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && bus.fft_complete_i) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end
  end

  // read issue -> RAM latency stages
  rd_valid_pipe #(
    .RD_LAT (RD_LAT),
    .ADDR_W (ADDR_W)
  ) u_rd_valid_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld_i     (rd_en_q),
    .addr_i    (rd_addr_a_q),
    .vld_o     (pipe_vld),
    .addr_o    (pipe_addr),
    .any_vld_o (pipe_any)
  );

  // RAM data -> display buffer write register
  always_comb begin
    done_d = pipe_vld;
    wa1_d  = wa1_q;
    wa2_d  = wa2_q;
    s1r_d  = s1r_q;
    s1i_d  = s1i_q;
    s2r_d  = s2r_q;
    s2i_d  = s2i_q;
    if (pipe_vld) begin
      wa1_d = pipe_addr;
      wa2_d = pipe_addr | ADDR_W'(1);
      s1r_d = bus.fft_rdata_a_real_i;
      s1i_d = bus.fft_rdata_a_img_i;
      s2r_d = bus.fft_rdata_b_real_i;
      s2i_d = bus.fft_rdata_b_img_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      k_q         <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      done_q      <= 1'b0;
      wa1_q       <= '0;
      wa2_q       <= '0;
      s1r_q       <= '0;
      s1i_q       <= '0;
      s2r_q       <= '0;
      s2i_q       <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      k_q         <= k_d;
      rd_en_q     <= rd_en_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      done_q      <= done_d;
      wa1_q       <= wa1_d;
      wa2_q       <= wa2_d;
      s1r_q       <= s1r_d;
      s1i_q       <= s1i_d;
      s2r_q       <= s2r_d;
      s2i_q       <= s2i_d;
    end
  end

  assign bus.fft_rd_en_o                 = rd_en_q;
  assign bus.fft_rd_addr_a_o             = rd_addr_a_q;
  assign bus.fft_rd_addr_b_o             = rd_addr_b_q;
  assign bus.fft_sample1_real_o          = s1r_q;
  assign bus.fft_sample1_img_o           = s1i_q;
  assign bus.fft_sample2_real_o          = s2r_q;
  assign bus.fft_sample2_img_o           = s2i_q;
  assign bus.write_vga_buffer_address1_o = wa1_q;
  assign bus.write_vga_buffer_address2_o = wa2_q;
  assign bus.fft_done_o                  = done_q;
  assign bus.vga_start_o                 = (state_q == ST_START);
  assign bus.busy_o                      = (state_q != ST_IDLE);
  assign bus.overrun_o                   = overrun_q;

endmodule

// File: tb/tb_fft_result_streamer.sv
`timescale 1ns/1ps
module tb_fft_result_streamer;

  localparam int N0 = 1024;
  localparam int A0 = 10;
  localparam int L0 = 2;
  localparam int NS = 16;
  localparam int AS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;
  int q0[$];
  int q1[$];
  int q4[$];

  fft_result_streamer_if #(.ADDR_W(A0), .DATA_W(32)) bus0 ();
  fft_result_streamer_if #(.ADDR_W(AS), .DATA_W(32)) bus1 ();
  fft_result_streamer_if #(.ADDR_W(AS), .DATA_W(32)) bus4 ();

  fft_result_streamer #(.N_POINTS(N0), .ADDR_W(A0), .DATA_W(32), .RD_LAT(L0)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  fft_result_streamer #(.N_POINTS(NS), .ADDR_W(AS), .DATA_W(32), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  fft_result_streamer #(.N_POINTS(NS), .ADDR_W(AS), .DATA_W(32), .RD_LAT(4)) u_lat4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4));

  // Result RAM models: real = bin address, img = ~real, fixed read latency.
  logic [A0-1:0] r0a [L0];
  logic [A0-1:0] r0b [L0];
  always @(posedge clk) begin
    r0a[0] <= bus0.fft_rd_addr_a_o;
    r0b[0] <= bus0.fft_rd_addr_b_o;
    for (int i = 1; i < L0; i++) begin
      r0a[i] <= r0a[i-1];
      r0b[i] <= r0b[i-1];
    end
  end
  assign bus0.fft_rdata_a_real_i = 32'(r0a[L0-1]);
  assign bus0.fft_rdata_a_img_i  = ~32'(r0a[L0-1]);
  assign bus0.fft_rdata_b_real_i = 32'(r0b[L0-1]);
  assign bus0.fft_rdata_b_img_i  = ~32'(r0b[L0-1]);

  logic [AS-1:0] r1a, r1b;
  always @(posedge clk) begin
    r1a <= bus1.fft_rd_addr_a_o;
    r1b <= bus1.fft_rd_addr_b_o;
  end
  assign bus1.fft_rdata_a_real_i = 32'(r1a);
  assign bus1.fft_rdata_a_img_i  = ~32'(r1a);
  assign bus1.fft_rdata_b_real_i = 32'(r1b);
  assign bus1.fft_rdata_b_img_i  = ~32'(r1b);

  logic [AS-1:0] r4a [4];
  logic [AS-1:0] r4b [4];
  always @(posedge clk) begin
    r4a[0] <= bus4.fft_rd_addr_a_o;
    r4b[0] <= bus4.fft_rd_addr_b_o;
    for (int i = 1; i < 4; i++) begin
      r4a[i] <= r4a[i-1];
      r4b[i] <= r4b[i-1];
    end
  end
  assign bus4.fft_rdata_a_real_i = 32'(r4a[3]);
  assign bus4.fft_rdata_a_img_i  = ~32'(r4a[3]);
  assign bus4.fft_rdata_b_real_i = 32'(r4b[3]);
  assign bus4.fft_rdata_b_img_i  = ~32'(r4b[3]);

  // Snapshot of every output of the main instance (173 bits).
  function automatic logic [172:0] snap0();
    return {bus0.fft_rd_en_o, bus0.fft_rd_addr_a_o, bus0.fft_rd_addr_b_o,
            bus0.fft_sample1_real_o, bus0.fft_sample1_img_o,
            bus0.fft_sample2_real_o, bus0.fft_sample2_img_o,
            bus0.write_vga_buffer_address1_o, bus0.write_vga_buffer_address2_o,
            bus0.fft_done_o, bus0.vga_start_o, bus0.busy_o, bus0.overrun_o};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (snap0() !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", snap0());
    end
    checks++;
    if ({bus1.fft_done_o, bus1.busy_o, bus4.fft_done_o, bus4.busy_o} !== 4'b0) begin
      errors++;
      $display("FAIL reset_small got %b want 0000",
               {bus1.fft_done_o, bus1.busy_o, bus4.fft_done_o, bus4.busy_o});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One full frame on the main instance; rel>0 holds vga_busy_i for rel cycles after E0.
  task automatic run_frame(input string name, input int rel);
    int d, ea, nstr, nstart;
    logic exp_rd, exp_done, exp_start, exp_busy;
    d = (rel > 0) ? rel + 1 : 0;
    nstr = 0;
    nstart = 0;
    for (int p = 0; p < N0 / 2; p++) q0.push_back(2 * p);
    bus0.vga_busy_i     = (rel > 0);
    bus0.fft_complete_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.fft_complete_i = 1'b0;
    checks++;
    if (bus0.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_E0 got %b want 1", name, bus0.busy_o);
    end
    for (int k = 1; k <= d + 520; k++) begin
      @(negedge clk);
      exp_rd    = (k >= d + 1) && (k <= d + 512);
      exp_done  = (k >= d + 2 + L0) && (k <= d + 1 + L0 + 512);
      exp_start = (k == d + 2 + L0 + 512);
      exp_busy  = (k <= d + 2 + L0 + 512);
      checks++;
      if ({bus0.fft_rd_en_o, bus0.fft_done_o, bus0.vga_start_o, bus0.busy_o} !==
          {exp_rd, exp_done, exp_start, exp_busy}) begin
        errors++;
        $display("FAIL %s ctrl k=%0d got rd/done/start/busy=%b%b%b%b want %b%b%b%b", name, k,
                 bus0.fft_rd_en_o, bus0.fft_done_o, bus0.vga_start_o, bus0.busy_o,
                 exp_rd, exp_done, exp_start, exp_busy);
      end
      if (bus0.vga_start_o) nstart++;
      if (bus0.fft_done_o) begin
        nstr++;
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL %s extra_strobe k=%0d got strobe want none", name, k);
        end else begin
          ea = q0.pop_front();
          if ({bus0.write_vga_buffer_address1_o, bus0.write_vga_buffer_address2_o,
               bus0.fft_sample1_real_o, bus0.fft_sample1_img_o,
               bus0.fft_sample2_real_o, bus0.fft_sample2_img_o} !==
              {A0'(ea), A0'(ea + 1), 32'(ea), ~32'(ea), 32'(ea + 1), ~32'(ea + 1)}) begin
            errors++;
            $display("FAIL %s data k=%0d got a1=%0d a2=%0d r1=%h i1=%h r2=%h i2=%h want a1=%0d a2=%0d",
                     name, k, bus0.write_vga_buffer_address1_o, bus0.write_vga_buffer_address2_o,
                     bus0.fft_sample1_real_o, bus0.fft_sample1_img_o,
                     bus0.fft_sample2_real_o, bus0.fft_sample2_img_o, ea, ea + 1);
          end
        end
      end
      if (rel > 0 && k == rel) bus0.vga_busy_i = 1'b0;
    end
    checks++;
    if (nstr != N0 / 2 || nstart != 1 || q0.size() != 0) begin
      errors++;
      $display("FAIL %s totals got strobes=%0d starts=%0d left=%0d want %0d 1 0",
               name, nstr, nstart, q0.size(), N0 / 2);
    end
    q0.delete();
  endtask

  task automatic test_basic_frame();
    run_frame("basic", 0);
  endtask

  task automatic test_display_busy();
    run_frame("disp_busy", 100);
  endtask

  task automatic test_back_to_back();
    int ea, nstart, nover, nstr;
    logic exp_rd, exp_done, exp_start, exp_over;
    nstart = 0;
    nover = 0;
    nstr = 0;
    for (int p = 0; p < N0 / 2; p++) q0.push_back(2 * p);
    bus0.vga_busy_i     = 1'b0;
    bus0.fft_complete_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.fft_complete_i = 1'b0;
    for (int k = 1; k <= 1040; k++) begin
      @(negedge clk);
      exp_rd    = (k >= 1 && k <= 512) || (k >= 519 && k <= 1030);
      exp_done  = (k >= 4 && k <= 515) || (k >= 522 && k <= 1033);
      exp_start = (k == 516) || (k == 1034);
      exp_over  = (k == 301);
      checks++;
      if ({bus0.fft_rd_en_o, bus0.fft_done_o, bus0.vga_start_o, bus0.overrun_o} !==
          {exp_rd, exp_done, exp_start, exp_over}) begin
        errors++;
        $display("FAIL b2b ctrl k=%0d got rd/done/start/ovr=%b%b%b%b want %b%b%b%b", k,
                 bus0.fft_rd_en_o, bus0.fft_done_o, bus0.vga_start_o, bus0.overrun_o,
                 exp_rd, exp_done, exp_start, exp_over);
      end
      if (bus0.vga_start_o) nstart++;
      if (bus0.overrun_o) nover++;
      if (bus0.fft_done_o) begin
        nstr++;
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL b2b extra_strobe k=%0d got strobe want none", k);
        end else begin
          ea = q0.pop_front();
          if ({bus0.write_vga_buffer_address1_o, bus0.write_vga_buffer_address2_o,
               bus0.fft_sample1_real_o, bus0.fft_sample2_img_o} !==
              {A0'(ea), A0'(ea + 1), 32'(ea), ~32'(ea + 1)}) begin
            errors++;
            $display("FAIL b2b data k=%0d got a1=%0d a2=%0d want a1=%0d a2=%0d", k,
                     bus0.write_vga_buffer_address1_o, bus0.write_vga_buffer_address2_o,
                     ea, ea + 1);
          end
        end
      end
      if (k == 200) begin
        bus0.fft_complete_i = 1'b1;
        for (int p = 0; p < N0 / 2; p++) q0.push_back(2 * p);
      end
      if (k == 300) bus0.fft_complete_i = 1'b1;
      if (k == 201 || k == 301) bus0.fft_complete_i = 1'b0;
    end
    checks++;
    if (nstart != 2 || nover != 1 || nstr != N0 || bus0.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b totals got starts=%0d overruns=%0d strobes=%0d busy=%b want 2 1 %0d 0",
               nstart, nover, nstr, bus0.busy_o, N0);
    end
    q0.delete();
  endtask

  task automatic test_reset_mid();
    int ea, bad;
    for (int p = 0; p < N0 / 2; p++) q0.push_back(2 * p);
    bus0.vga_busy_i     = 1'b0;
    bus0.fft_complete_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.fft_complete_i = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (bus0.fft_done_o) begin
        ea = q0.pop_front();
        checks++;
        if (bus0.write_vga_buffer_address1_o !== A0'(ea)) begin
          errors++;
          $display("FAIL rst_mid pre_data k=%0d got %0d want %0d", k,
                   bus0.write_vga_buffer_address1_o, ea);
        end
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (snap0() !== '0) begin
      errors++;
      $display("FAIL rst_mid outputs got %h want 0", snap0());
    end
    rst_n = 1'b1;
    q0.delete();
    bad = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (bus0.fft_done_o || bus0.vga_start_o || bus0.busy_o) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_mid aborted got %0d active cycles want 0", bad);
    end
    run_frame("restart", 0);
  endtask

  task automatic test_latency_sweep();
    int ea, n1, n4;
    logic e1, e4, st1, st4;
    n1 = 0;
    n4 = 0;
    for (int p = 0; p < NS / 2; p++) begin
      q1.push_back(2 * p);
      q4.push_back(2 * p);
    end
    bus1.vga_busy_i = 1'b0;
    bus4.vga_busy_i = 1'b0;
    bus1.fft_complete_i = 1'b1;
    bus4.fft_complete_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.fft_complete_i = 1'b0;
    bus4.fft_complete_i = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      e1  = (k >= 3) && (k <= 10);
      e4  = (k >= 6) && (k <= 13);
      st1 = (k == 11);
      st4 = (k == 14);
      checks++;
      if ({bus1.fft_done_o, bus1.vga_start_o, bus4.fft_done_o, bus4.vga_start_o} !==
          {e1, st1, e4, st4}) begin
        errors++;
        $display("FAIL lat_sweep ctrl k=%0d got l1 done/start=%b%b l4=%b%b want %b%b %b%b", k,
                 bus1.fft_done_o, bus1.vga_start_o, bus4.fft_done_o, bus4.vga_start_o,
                 e1, st1, e4, st4);
      end
      if (bus1.fft_done_o && q1.size() > 0) begin
        n1++;
        ea = q1.pop_front();
        checks++;
        if ({bus1.write_vga_buffer_address1_o, bus1.write_vga_buffer_address2_o,
             bus1.fft_sample1_real_o, bus1.fft_sample2_img_o} !==
            {AS'(ea), AS'(ea + 1), 32'(ea), ~32'(ea + 1)}) begin
          errors++;
          $display("FAIL lat1 data k=%0d got a1=%0d a2=%0d want %0d %0d", k,
                   bus1.write_vga_buffer_address1_o, bus1.write_vga_buffer_address2_o, ea, ea + 1);
        end
      end
      if (bus4.fft_done_o && q4.size() > 0) begin
        n4++;
        ea = q4.pop_front();
        checks++;
        if ({bus4.write_vga_buffer_address1_o, bus4.write_vga_buffer_address2_o,
             bus4.fft_sample1_img_o, bus4.fft_sample2_real_o} !==
            {AS'(ea), AS'(ea + 1), ~32'(ea), 32'(ea + 1)}) begin
          errors++;
          $display("FAIL lat4 data k=%0d got a1=%0d a2=%0d want %0d %0d", k,
                   bus4.write_vga_buffer_address1_o, bus4.write_vga_buffer_address2_o, ea, ea + 1);
        end
      end
    end
    checks++;
    if (n1 != NS / 2 || n4 != NS / 2) begin
      errors++;
      $display("FAIL lat_sweep counts got %0d/%0d want %0d/%0d", n1, n4, NS / 2, NS / 2);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus0.fft_complete_i = 1'b0;
    bus0.vga_busy_i     = 1'b0;
    bus1.fft_complete_i = 1'b0;
    bus1.vga_busy_i     = 1'b0;
    bus4.fft_complete_i = 1'b0;
    bus4.vga_busy_i     = 1'b0;
    test_reset();
    test_basic_frame();
    test_display_busy();
    test_back_to_back();
    test_reset_mid();
    test_latency_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_result_streamer.md
Name: fft_result_streamer

Overview:
- Producer end of the spectrum-display sample interface: reads finished FFT bins from the FFT result RAM two at a time and streams them, with write addresses and write strobe, into the display path's magnitude input buffer.
- When the last pair is written, it issues the one-cycle start pulse that launches max search, width adaptation and display.
- Sits between the FFT core and the VGA display block in the top level.

Parameters:
- N_POINTS, 1024, FFT length; number of bins transferred per frame. Power of two, at least 4.
- ADDR_W, 10, bin address width; log2(N_POINTS).
- DATA_W, 32, width of the real and imaginary parts of each bin.
- RD_LAT, 2, read latency of the FFT result RAM in clk cycles, from address to data. Range 1..4.

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  synchronous active-low reset.
- fft_complete_i  in  1  one-cycle pulse from the FFT core: result RAM holds a new frame.
- vga_busy_i  in  1  display path is still processing or showing the previous frame.
- fft_rd_en_o  out  1  read enable to the FFT result RAM.
- fft_rd_addr_a_o  out  ADDR_W  read address, port A (even bin).
- fft_rd_addr_b_o  out  ADDR_W  read address, port B (odd bin).
- fft_rdata_a_real_i / fft_rdata_a_img_i  in  DATA_W each  port A read data.
- fft_rdata_b_real_i / fft_rdata_b_img_i  in  DATA_W each  port B read data.
- fft_sample1_real_o / fft_sample1_img_o  out  DATA_W each  even-bin sample to the display buffer.
- fft_sample2_real_o / fft_sample2_img_o  out  DATA_W each  odd-bin sample to the display buffer.
- write_vga_buffer_address1_o / write_vga_buffer_address2_o  out  ADDR_W each  display buffer write addresses.
- fft_done_o  out  1  write strobe; high exactly on cycles where samples and addresses are valid.
- vga_start_o  out  1  one-cycle pulse after the last write of a frame.
- busy_o  out  1  high from frame acceptance until vga_start_o.
- overrun_o  out  1  one-cycle pulse when a frame is dropped.

Behaviour:
- Reset:
  - clk is the only clock; rst_n is synchronous and active-low.
  - Every output is 0 on the edge where rst_n is low, including the sample, address and pipeline registers.
  - State goes to IDLE and the pending flag clears.
  - Reset mid-transfer aborts the frame: no further fft_done_o and no vga_start_o.
- State machine: IDLE, WAIT_DISP, READ, DRAIN, START.
  - IDLE, fft_complete_i=1, vga_busy_i=0 -> READ.
  - IDLE, fft_complete_i=1, vga_busy_i=1 -> WAIT_DISP.
  - WAIT_DISP, vga_busy_i=0 -> READ.
  - READ: pair counter k runs 0..N_POINTS/2-1, one pair per cycle.
    - fft_rd_en_o=1, fft_rd_addr_a_o=2k, fft_rd_addr_b_o=2k+1, all registered.
    - After k=N_POINTS/2-1 -> DRAIN. The counter does not wrap.
  - DRAIN: waits until the pipeline valid bits are empty -> START.
  - START: vga_start_o=1 for one cycle -> IDLE.
- Write pipeline:
  - A delay line of RD_LAT stages carries {valid, 2k}.
  - The output register captures RAM data plus the delayed address when valid.
  - Outputs: write_vga_buffer_address1_o=2k, write_vga_buffer_address2_o=2k+1, fft_done_o=delayed valid.
  - When fft_done_o=0, sample and address outputs hold their last values.
- Latency:
  - fft_complete_i is sampled on edge E0. First fft_rd_en_o is high after E1.
  - First fft_done_o is high after edge E(2+RD_LAT).
  - fft_done_o stays high for N_POINTS/2 consecutive cycles.
  - vga_start_o is high the cycle immediately after the last fft_done_o.
- busy_o is high in every state except IDLE.
- Frame handling:
  - vga_busy_i is only checked on frame acceptance. Changes to it during READ, DRAIN or START are ignored.
  - fft_complete_i while busy_o=1 sets the pending flag. A pending frame starts from IDLE on the cycle after START, still subject to the vga_busy_i check.
  - fft_complete_i while busy_o=1 and pending already set: frame is dropped and overrun_o pulses one cycle.
  - fft_complete_i in the same cycle as START: sets pending, no overrun.

Decomposition:
- Shared package spectrum_pkg holds:
  - the state enum;
  - default constants FFT_N=1024, FFT_ADDR_W=10, FFT_DATA_W=32;
  - a helper constant for pair count (N/2).
- One natural sub-module: rd_valid_pipe, a parameterised RD_LAT-deep register chain carrying {valid, ADDR_W address}. It is the generalisation of the existing fixed two-stage address pipe.

Test Plan:
- Basic frame: RD_LAT=2, N=1024, RAM model returns real=addr, img=~addr; fft_complete_i at E0 with vga_busy_i=0.
  - fft_done_o high for 512 cycles after E4..E515.
  - Addresses 0/1 ... 1022/1023 with matching data.
  - vga_start_o pulse after E516; busy_o low after E517.
- Display busy: fft_complete_i with vga_busy_i=1, release after 100 cycles.
  - No fft_rd_en_o while busy; first read the cycle after release; full frame then follows.
- Back-to-back frames: second fft_complete_i at beat 200, third at beat 300.
  - Second frame runs right after START; third gives one overrun_o pulse.
  - Exactly two vga_start_o pulses total.
- Reset mid-transfer: rst_n low at beat 50 for 1 cycle.
  - All outputs 0 next edge; no vga_start_o.
  - Fresh fft_complete_i restarts from address 0.
- Latency sweep: RD_LAT=1 and 4, N=16.
  - First fft_done_o after E3 and E6 respectively.
  - Exactly 8 strobes per frame, in order, no gaps.
